// File: rtl/image_buffer_swap_arbiter.sv
// Double-buffer arbiter: routes the display reader to the front bank and the UART writer to the back bank,
// swapping tear-free after commit + frame boundary. Define IMAGEBUF_WR_STALL_EN to block writes while a swap is pending.
module image_buffer_swap_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_ready,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  commit,
  input  logic                  frame_ended,
  output logic                  bank0_req,
  output logic                  bank0_we,
  output logic [ADDR_WIDTH-1:0] bank0_addr,
  output logic [DATA_WIDTH-1:0] bank0_wdata,
  input  logic [DATA_WIDTH-1:0] bank0_rdata,
  input  logic                  bank0_ready,
  output logic                  bank1_req,
  output logic                  bank1_we,
  output logic [ADDR_WIDTH-1:0] bank1_addr,
  output logic [DATA_WIDTH-1:0] bank1_wdata,
  input  logic [DATA_WIDTH-1:0] bank1_rdata,
  input  logic                  bank1_ready,
  output logic                  front,
  output logic                  swap_pending,
  output logic                  swap_done,
  output logic [CNT_WIDTH-1:0]  swap_count,
  output logic [CNT_WIDTH-1:0]  drop_count
);

  typedef enum logic [1:0] {IDLE, PENDING, SWAP} state_t;

  state_t state;
  logic   rd_busy, wr_busy, fb_seen;
  logic   stall_rd, wr_block, front_req, back_req;
  logic   rd_busy_n, wr_busy_n, rd_new, can_swap;

  always_comb begin
    stall_rd = (state == SWAP);
`ifdef IMAGEBUF_WR_STALL_EN
    wr_block = (state != IDLE);
`else
    wr_block = (state == SWAP);
`endif
    front_req = rd_req & ~stall_rd;
    back_req  = wr_req & ~wr_block;
    rd_new    = front_req & ~rd_busy;
    rd_busy_n = (rd_busy | front_req) & ~rd_ready;
    wr_busy_n = (wr_busy | back_req) & ~wr_ready;
    // Gate on next-cycle busy so a request forwarded in this same cycle can never straddle the toggle.
    can_swap  = fb_seen & ~rd_new & ~rd_busy_n & ~wr_busy_n;
  end

  always_comb begin
    bank0_req   = 1'b0;
    bank0_we    = 1'b0;
    bank0_addr  = '0;
    bank0_wdata = '0;
    bank1_req   = 1'b0;
    bank1_we    = 1'b0;
    bank1_addr  = '0;
    bank1_wdata = '0;
    if (front) begin
      bank1_req   = front_req;
      bank1_addr  = rd_addr;
      bank0_req   = back_req;
      bank0_we    = 1'b1;
      bank0_addr  = wr_addr;
      bank0_wdata = wr_data;
    end else begin
      bank0_req   = front_req;
      bank0_addr  = rd_addr;
      bank1_req   = back_req;
      bank1_we    = 1'b1;
      bank1_addr  = wr_addr;
      bank1_wdata = wr_data;
    end
    rd_data  = front ? bank1_rdata : bank0_rdata;
    rd_ready = front ? bank1_ready : bank0_ready;
    wr_ready = front ? bank0_ready : bank1_ready;
  end

  assign swap_pending = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      front      <= 1'b0;
      swap_done  <= 1'b0;
      swap_count <= '0;
      drop_count <= '0;
      rd_busy    <= 1'b0;
      wr_busy    <= 1'b0;
      fb_seen    <= 1'b0;
    end else begin
      rd_busy   <= rd_busy_n;
      wr_busy   <= wr_busy_n;
      swap_done <= 1'b0;
      if (state == SWAP)
        fb_seen <= 1'b0;
      else if (frame_ended)
        fb_seen <= 1'b1;
      else if (rd_new)
        fb_seen <= 1'b0;
      case (state)
        IDLE: begin
          if (commit) state <= PENDING;
        end
        PENDING: begin
          if (commit) begin
            if (drop_count != '1) drop_count <= drop_count + CNT_WIDTH'(1);
          end else if (can_swap) begin
            state <= SWAP;
          end
        end
        SWAP: begin
          front      <= ~front;
          swap_done  <= 1'b1;
          swap_count <= swap_count + CNT_WIDTH'(1);
          state      <= commit ? PENDING : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
